// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
// TXDATA at BASE_ADDR queues a byte; STATUS at BASE_ADDR+4 reports FIFO/shifter state.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_FF00,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] writedata,
  input  logic        memwrite,
  output logic [31:0] readdata,
  output logic        hit,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          ovf;
  logic [BW-1:0] baud;
  logic [2:0]    bitcnt;
  logic [7:0]    shift;
  logic          sel_data, sel_stat, full, empty, busy, push, pop, bit_end;
  logic          unused;
  assign unused   = ^writedata[31:8];
  assign sel_data = addr == BASE_ADDR;
  assign sel_stat = addr == BASE_ADDR + 32'd4;
  assign hit      = sel_data | sel_stat;
  assign full     = count == (AW+1)'(FIFO_DEPTH);
  assign empty    = count == '0;
  assign busy     = state != IDLE || !empty;
  assign bit_end  = baud == BAUD_MAX;
  assign push     = memwrite && sel_data && !full;
  // STOP-end pop chains frames with no idle cycle in between
  assign pop      = !empty && (state == IDLE || (state == STOP && bit_end));
  assign readdata = sel_stat ? {24'd0, 4'(count), ovf, empty, full, busy} : 32'd0;
  always_ff @(posedge clock)
    if (push) mem[wptr] <= writedata[7:0];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (memwrite && sel_data && full) ovf <= 1'b1;
      else if (memwrite && sel_stat && writedata[3]) ovf <= 1'b0;
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state  <= IDLE;
      tx     <= 1'b1;
      baud   <= '0;
      bitcnt <= '0;
      shift  <= '0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          shift  <= mem[rptr];
          bitcnt <= '0;
          baud   <= '0;
          state  <= START;
          tx     <= 1'b0;
        end
        START: begin
          baud <= bit_end ? '0 : baud + BW'(1);
          if (bit_end) begin
            state <= DATA;
            tx    <= shift[0];
          end
        end
        DATA: begin
          baud <= bit_end ? '0 : baud + BW'(1);
          if (bit_end) begin
            shift  <= shift >> 1;
            bitcnt <= bitcnt + 3'd1;
            tx     <= (bitcnt == 3'd7) ? 1'b1 : shift[1];
            if (bitcnt == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          baud <= bit_end ? '0 : baud + BW'(1);
          if (bit_end) begin
            state <= pop ? START : IDLE;
            tx    <= !pop;
            if (pop) begin
              shift  <= mem[rptr];
              bitcnt <= '0;
            end
          end
        end
      endcase
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: table vectors, directed corner sequences and random traffic
// checked every cycle against a queue-based model of the FIFO and serial line.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE = 32'h0000_FF00;
  localparam logic [31:0] STAT = BASE + 32'd4;
  localparam int CPB = 4;
  localparam int D   = 4;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr, writedata;
  logic        memwrite;
  logic [31:0] readdata;
  logic        hit, tx;
  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;
  logic [7:0] q[$];
  logic       sched[$];
  logic       m_tx, m_act, m_ovf;
  typedef struct {
    logic [31:0] a;
    logic        h;
    logic [31:0] rd;
  } vec_t;
  vec_t vecs[6];

  mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .addr(addr), .writedata(writedata),
    .memwrite(memwrite), .readdata(readdata), .hit(hit), .tx(tx)
  );

  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    sched.delete();
    m_tx  = 1'b1;
    m_act = 1'b0;
    m_ovf = 1'b0;
  endtask

  // One rising edge of the reference: the line plays a 40-sample frame per byte.
  task automatic model_edge();
    int n = q.size();
    logic [7:0] b;
    if (sched.size() == 0) begin
      if (n > 0) begin
        b = q.pop_front();
        for (int i = 0; i < 10; i++)
          repeat (CPB) sched.push_back(i == 0 ? 1'b0 : i == 9 ? 1'b1 : b[i-1]);
        m_tx  = sched.pop_front();
        m_act = 1'b1;
      end else begin
        m_tx  = 1'b1;
        m_act = 1'b0;
      end
    end else m_tx = sched.pop_front();
    if (memwrite && addr == BASE) begin
      if (n < D) q.push_back(writedata[7:0]);
      else m_ovf = 1'b1;
    end
    if (memwrite && addr == STAT && writedata[3]) m_ovf = 1'b0;
  endtask

  function automatic logic [31:0] exp_status();
    int n = q.size();
    return {24'd0, 4'(n), m_ovf, n == 0, n == D, m_act || n > 0};
  endfunction

  task automatic check_all();
    chk("tx", 32'(tx), 32'(m_tx));
    chk("hit", 32'(hit), 32'(addr == BASE || addr == STAT));
    chk("readdata", readdata, addr == STAT ? exp_status() : 32'd0);
  endtask

  task automatic cyc();
    @(posedge clock);
    model_edge();
    cyc_n++;
    @(negedge clock);
    check_all();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    writedata = d;
    memwrite  = 1'b1;
    cyc();
    memwrite  = 1'b0;
    addr      = STAT;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    addr = STAT;
    #1;
    while (readdata[0] !== 1'b0 && n < bound) begin
      cyc();
      n++;
    end
    chk("idle_reached", 32'(n < bound), 32'd1);
  endtask

  initial begin
    logic [9:0] frame;
    int n0;
    addr = STAT;
    writedata = '0;
    memwrite = 1'b0;
    model_reset();
    vecs[0] = '{BASE, 1'b1, 32'h0};
    vecs[1] = '{STAT, 1'b1, 32'h4};
    vecs[2] = '{BASE + 32'd8, 1'b0, 32'h0};
    vecs[3] = '{BASE - 32'd4, 1'b0, 32'h0};
    vecs[4] = '{BASE + 32'd1, 1'b0, 32'h0};
    vecs[5] = '{32'h1000_FF04, 1'b0, 32'h0};
    repeat (3) @(posedge clock);
    #1 chk("tx_in_reset", 32'(tx), 32'd1);
    @(negedge clock) reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      addr = vecs[i].a;
      cyc();
      chk("vec_hit", 32'(hit), 32'(vecs[i].h));
      chk("vec_rd", readdata, vecs[i].rd);
    end
    addr = STAT;
    // single byte: exact waveform of 0x55
    store(BASE, 32'hABCD_0055);
    frame = {1'b1, 8'h55, 1'b0};
    for (int k = 0; k < 10 * CPB; k++) begin
      cyc();
      chk("frame55", 32'(tx), 32'(frame[k/CPB]));
    end
    cyc();
    chk("status_after_frame", readdata, 32'h4);
    // back-to-back frames
    store(BASE, 32'h01);
    store(BASE, 32'h02);
    store(BASE, 32'h03);
    #1 chk("b2b_count", readdata, 32'h21);
    for (int k = 0; k < 118; k++) begin
      cyc();
      chk("b2b_busy", 32'(readdata[0]), 32'd1);
    end
    cyc();
    chk("b2b_done", readdata, 32'h4);
    // overflow while first frame is in START
    n0 = cyc_n + 1;
    for (int i = 0; i < 6; i++) store(BASE, 32'h10 + 32'(i));
    #1 chk("ovf_status", readdata, 32'h4B);
    store(STAT, 32'h8);
    #1 chk("ovf_cleared", readdata, 32'h43);
    wait_idle(400);
    chk("ovf_five_frames", 32'(cyc_n - n0), 32'd201);
    // push on STOP-end pop edge with count 2
    store(BASE, 32'hA1);
    store(BASE, 32'hB2);
    store(BASE, 32'hC3);
    repeat (38) cyc();
    store(BASE, 32'hD4);
    #1 chk("pushpop_count", readdata, 32'h21);
    wait_idle(400);
    // push on pop edge while full
    for (int i = 0; i < 5; i++) store(BASE, 32'h60 + 32'(i));
    repeat (36) cyc();
    store(BASE, 32'hEE);
    #1 chk("full_pop_drop", readdata, 32'h39);
    store(STAT, 32'hFFFF_FFF8);
    #1 chk("full_ovf_clear", readdata, 32'h31);
    wait_idle(400);
    // reset during DATA bit 3
    store(BASE, 32'hF0);
    store(BASE, 32'h33);
    repeat (16) cyc();
    chk("pre_reset_tx", 32'(tx), 32'd0);
    #2 reset = 1'b0;
    #1 chk("async_tx_high", 32'(tx), 32'd1);
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    addr = STAT;
    #1 chk("status_after_reset", readdata, 32'h4);
    repeat (60) cyc();
    chk("no_residual", readdata, 32'h4);
    // random traffic
    repeat (3000) begin
      int r = $urandom_range(0, 99);
      int s = $urandom_range(0, 3);
      memwrite  = r < 14;
      addr      = r < 10 ? BASE : r < 13 ? STAT : s == 0 ? BASE : s == 1 ? STAT :
                  s == 2 ? BASE + 32'd8 : $urandom;
      writedata = $urandom;
      cyc();
    end
    memwrite = 1'b0;
    wait_idle(2000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
